lz77_match_engine: RTL and testbench

LZ77_MATCH_ENGINE -- requirements
Module: lz77_match_engine

---
 rtl/lz77_match_engine.sv | 189 ++++++++++++++++++
 tb/tb_lz77_match_engine.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lz77_match_engine.sv
// lz77_match_engine
// Brute-force LZ77 longest-match search over an external search window.
// An 8-byte lookahead is loaded in IDLE. An accepted start then walks every
// window start position s. For each s it reads window bytes one at a time,
// at address s+k, and compares them with la[k]. When the walk ends, one
// (offset, length, next-byte) token is emitted.
//
// Optional build macro: LZ77_MATCH_EARLY_EXIT_EN
//   defined   -> stop at the first match of maximal length (farthest wins)
//   undefined -> search every start position (nearest maximal match wins)

module lz77_match_engine #(
  parameter int DATA_W    = 8,
  parameter int WIN_DEPTH = 64,
  parameter int ADDR_W    = 7,
  parameter int LA_LEN    = 8,
  parameter int LEN_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] win_len,
  input  logic              la_wr,
  input  logic [DATA_W-1:0] la_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              tok_valid,
  input  logic              tok_ready,
  output logic [ADDR_W-1:0] tok_offset,
  output logic [LEN_W-1:0]  tok_length,
  output logic [DATA_W-1:0] tok_next,
  output logic              busy
);

  localparam int CNT_W = $clog2(LA_LEN + 1);
  localparam int LA_AW = $clog2(LA_LEN);
  localparam int EXT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LA_FULL = CNT_W'(LA_LEN);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(LA_LEN - 1);

  // Token handshake: tok_valid rises when EMIT is entered. While
  // tok_valid=1 && tok_ready=0, tok_offset/tok_length/tok_next do not change.
  // The token is transferred on the rising edge where tok_valid && tok_ready.
  // On that same edge tok_valid falls and the engine returns to IDLE.

  typedef enum logic [1:0] {IDLE, READ, CMP, EMIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   la [LA_LEN];
  logic [CNT_W-1:0]    la_cnt;
  logic [ADDR_W-1:0]   s;
  logic [ADDR_W-1:0]   wl;
  logic [LEN_W-1:0]    k;
  logic [LEN_W-1:0]    best_len;
  logic [ADDR_W-1:0]   best_off;

  logic                start_ok;
  logic                eq;
  logic                cont;
  logic                s_last;
  logic                early_exit;
  logic                upd;
  logic [EXT_W-1:0]    pos_next;
  logic [LEN_W-1:0]    cand;
  logic [LEN_W-1:0]    nb_len;
  logic [ADDR_W-1:0]   nb_off;
  logic [ADDR_W-1:0]   s_inc;

  assign start_ok = start && (la_cnt == LA_FULL);

  // Compare step: decide whether to extend the current candidate, and
  // what the best match becomes if the candidate ends here.
  always_comb begin
    eq       = (rd_data == la[k[LA_AW-1:0]]);
    pos_next = EXT_W'(s) + EXT_W'(k) + 1'b1;
    cont     = eq && ((k + 1'b1) < MAX_LEN) && (pos_next < EXT_W'(wl));
    cand     = k + LEN_W'(eq);
    // ">=" lets a later, nearer start position replace an equal-length match.
    upd      = (cand != '0) && (cand >= best_len);
    nb_len   = upd ? cand : best_len;
    nb_off   = upd ? (wl - s) : best_off;
    s_inc    = s + 1'b1;
    s_last   = (s_inc == wl);
`ifdef LZ77_MATCH_EARLY_EXIT_EN
    early_exit = (nb_len == MAX_LEN);
`else
    early_exit = 1'b0;
`endif
  end

  // Lookahead storage: filled in IDLE until full; not reset because la_cnt
  // marks which entries are valid.
  always_ff @(posedge clk) begin
    if (!rst && state == IDLE && la_wr && la_cnt != LA_FULL) begin
      la[la_cnt[LA_AW-1:0]] <= la_data;
    end
  end

  // Search FSM with registered read-request, token and busy outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      la_cnt     <= '0;
      s          <= '0;
      k          <= '0;
      wl         <= '0;
      best_len   <= '0;
      best_off   <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      tok_valid  <= 1'b0;
      tok_offset <= '0;
      tok_length <= '0;
      tok_next   <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (la_wr && la_cnt != LA_FULL) begin
            la_cnt <= la_cnt + 1'b1;
          end
          if (start_ok) begin
            s        <= '0;
            k        <= '0;
            best_len <= '0;
            best_off <= '0;
            wl       <= win_len;
            busy     <= 1'b1;
            if (win_len == '0) begin
              // An empty window can only produce a literal.
              state      <= EMIT;
              tok_valid  <= 1'b1;
              tok_offset <= '0;
              tok_length <= '0;
              tok_next   <= la[0];
            end else begin
              state   <= READ;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        READ: begin
          rd_en <= 1'b0;
          state <= CMP;
        end
        CMP: begin
          if (cont) begin
            k       <= k + 1'b1;
            state   <= READ;
            rd_en   <= 1'b1;
            rd_addr <= pos_next[ADDR_W-1:0];
          end else begin
            best_len <= nb_len;
            best_off <= nb_off;
            s        <= s_inc;
            k        <= '0;
            if (s_last || early_exit) begin
              state      <= EMIT;
              tok_valid  <= 1'b1;
              tok_offset <= nb_off;
              tok_length <= nb_len;
              tok_next   <= la[nb_len[LA_AW-1:0]];
            end else begin
              state   <= READ;
              rd_en   <= 1'b1;
              rd_addr <= s_inc;
            end
          end
        end
        EMIT: begin
          if (tok_ready) begin
            tok_valid <= 1'b0;
            la_cnt    <= '0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          rd_en <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_match_engine.sv
// tb_lz77_match_engine
// Directed and randomized checks of lz77_match_engine. The bench holds a
// behavioural match model and a window memory with one cycle of read
// latency. Respects LZ77_MATCH_EARLY_EXIT_EN when it is defined.

module tb_lz77_match_engine;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 7;
  localparam int LA_LEN = 8;
  localparam int LEN_W  = 4;
  localparam int TOK_W  = ADDR_W + LEN_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] win_len = '0;
  logic              la_wr = 1'b0;
  logic [DATA_W-1:0] la_data = '0;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data = '0;
  logic              tok_valid;
  logic              tok_ready = 1'b0;
  logic [ADDR_W-1:0] tok_offset;
  logic [LEN_W-1:0]  tok_length;
  logic [DATA_W-1:0] tok_next;
  logic              busy;

  logic [DATA_W-1:0] win_mem [128];
  logic [DATA_W-1:0] la_buf [LA_LEN];
  logic [TOK_W-1:0]  exp_q [$];
  int                exp_busy;
  int                exp_cmps;
  int                tests = 0;
  int                fails = 0;
  int                rd_cnt = 0;
  int                oob_cnt = 0;
  int                cur_wl = 0;

  lz77_match_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .win_len    (win_len),
    .la_wr      (la_wr),
    .la_data    (la_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_offset (tok_offset),
    .tok_length (tok_length),
    .tok_next   (tok_next),
    .busy       (busy)
  );

  // Clock
  always #5 clk = ~clk;

  // Window memory: the byte is valid one cycle after the request. Each
  // request is also checked against the current window length.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data <= win_mem[rd_addr];
      rd_cnt   = rd_cnt + 1;
      if (int'(rd_addr) >= cur_wl) oob_cnt = oob_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input string str);
    for (int i = 0; i < 128; i++) win_mem[i] = 8'h00;
    for (int i = 0; i < str.len(); i++) win_mem[i] = str[i];
  endtask

  task automatic set_la(input string str);
    for (int i = 0; i < LA_LEN; i++) la_buf[i] = str[i];
  endtask

  task automatic write_la(input int from, input int to);
    for (int i = from; i < to; i++) begin
      la_wr   = 1'b1;
      la_data = la_buf[i];
      tick();
    end
    la_wr = 1'b0;
  endtask

  // Reference: for each start position, find the longest prefix of the
  // lookahead that matches, capped at LA_LEN-1 and at the window end.
  // Keep the best match, taking the later start on ties. Also count the
  // byte comparisons, each of which costs two cycles.
  task automatic model(input int wl);
    int best_l, best_o, cmps, lim, l;
    best_l = 0;
    best_o = 0;
    cmps   = 0;
    for (int s = 0; s < wl; s++) begin
      lim = (wl - s < LA_LEN - 1) ? wl - s : LA_LEN - 1;
      l = 0;
      while (l < lim && win_mem[s + l] == la_buf[l]) l++;
      cmps += (l < lim) ? l + 1 : l;
      if (l > 0 && l >= best_l) begin
        best_l = l;
        best_o = wl - s;
      end
`ifdef LZ77_MATCH_EARLY_EXIT_EN
      if (best_l == LA_LEN - 1) break;
`endif
    end
    exp_cmps = cmps;
    exp_busy = 2 * cmps + 1;
    exp_q.push_back({ADDR_W'(best_o), LEN_W'(best_l), la_buf[best_l]});
  endtask

  // Load the lookahead if asked, start a search, wait for the token and
  // compare it. Then hold tok_ready low for 'hold' cycles while the
  // testbench pulses la_wr, and finally accept the token.
  task automatic run_search(input int wl, input int hold, input bit do_load,
                            input bit directed, input int d_off, input int d_len,
                            input byte d_next, input string tag);
    logic [TOK_W-1:0] t;
    logic [ADDR_W-1:0] e_off;
    logic [LEN_W-1:0] e_len;
    logic [DATA_W-1:0] e_next;
    int busy_cnt, rd0, oob0;
    bit seen;
    if (do_load) write_la(0, LA_LEN);
    cur_wl = wl;
    model(wl);
    t = exp_q.pop_front();
    {e_off, e_len, e_next} = t;
    if (directed) begin
      e_off  = ADDR_W'(d_off);
      e_len  = LEN_W'(d_len);
      e_next = d_next;
    end
    rd0  = rd_cnt;
    oob0 = oob_cnt;
    win_len = ADDR_W'(wl);
    start = 1'b1;
    tick();
    start = 1'b0;
    busy_cnt = 0;
    seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      if (busy) busy_cnt++;
      if (tok_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_tok_valid"}, 32'(seen), 32'd1);
    check({tag, "_offset"}, 32'(tok_offset), 32'(e_off));
    check({tag, "_length"}, 32'(tok_length), 32'(e_len));
    check({tag, "_next"}, 32'(tok_next), 32'(e_next));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    check({tag, "_rd_pulses"}, 32'(rd_cnt - rd0), 32'(exp_cmps));
    check({tag, "_rd_in_window"}, 32'(oob_cnt - oob0), 32'd0);
    for (int h = 0; h < hold; h++) begin
      la_wr   = 1'b1;
      la_data = 8'($urandom);
      tick();
      check({tag, "_hold_valid"}, 32'(tok_valid), 32'd1);
      check({tag, "_hold_offset"}, 32'(tok_offset), 32'(e_off));
      check({tag, "_hold_length"}, 32'(tok_length), 32'(e_len));
      check({tag, "_hold_next"}, 32'(tok_next), 32'(e_next));
    end
    la_wr = 1'b0;
    tok_ready = 1'b1;
    tick();
    tok_ready = 1'b0;
    check({tag, "_valid_after_accept"}, 32'(tok_valid), 32'd0);
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd0);
  endtask

  initial begin
    string alpha;
    int wl;
    for (int i = 0; i < 128; i++) win_mem[i] = 8'h00;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tok_valid", 32'(tok_valid), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_tok_offset", 32'(tok_offset), 32'd0);
    check("rst_tok_length", 32'(tok_length), 32'd0);
    check("rst_tok_next", 32'(tok_next), 32'd0);

    // Basic match: ABCD window, ABC prefix
    set_win("ABCD");
    set_la("ABCXYZQR");
    run_search(4, 0, 1'b1, 1'b1, 4, 3, "X", "abcd");

    // Empty window gives a literal one cycle after start
    set_la("QRSTUVWX");
    run_search(0, 0, 1'b1, 1'b1, 0, 0, "Q", "empty_win");

    // No match; tok_ready held low for 5 cycles while la_wr pulses
    set_win("AAAA");
    set_la("BBBBBBBB");
    run_search(4, 5, 1'b1, 1'b1, 0, 0, "B", "nomatch_hold");

    // Lookahead count cleared on accept: 7 writes are not enough to start
    set_win("CABCDABC");
    set_la("ABCDEFGH");
    write_la(0, 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("la_cnt_cleared_busy0", 32'(busy), 32'd0);
    tick();
    check("la_cnt_cleared_busy1", 32'(busy), 32'd0);
    write_la(7, 8);
    run_search(8, 0, 1'b0, 1'b0, 0, 0, 0, "after_clear");

    // All-A window and lookahead: length capped at LA_LEN-1
    set_win("AAAAAAAAAA");
    set_la("AAAAAAAA");
`ifdef LZ77_MATCH_EARLY_EXIT_EN
    run_search(10, 0, 1'b1, 1'b1, 10, 7, "A", "all_a");
`else
    run_search(10, 0, 1'b1, 1'b1, 7, 7, "A", "all_a");
`endif

    // Reset during CMP aborts the search
    set_win("AAAAAAAAAA");
    set_la("AAAABBBB");
    write_la(0, LA_LEN);
    cur_wl = 10;
    win_len = 7'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_read_rd_en", 32'(rd_en), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_tok_valid", 32'(tok_valid), 32'd0);
    check("abort_rd_en", 32'(rd_en), 32'd0);
    rst = 1'b0;
    write_la(0, 5);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("short_la_busy0", 32'(busy), 32'd0);
    tick();
    check("short_la_busy1", 32'(busy), 32'd0);
    check("short_la_tok_valid", 32'(tok_valid), 32'd0);
    write_la(5, 8);
    run_search(10, 0, 1'b0, 1'b0, 0, 0, 0, "after_abort");

    // Randomized searches over a small alphabet so matches are common
    alpha = "ABC";
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 128; i++) win_mem[i] = 8'h00;
      wl = $urandom_range(0, 24);
      for (int i = 0; i < wl; i++) win_mem[i] = alpha[$urandom_range(0, 2)];
      for (int i = 0; i < LA_LEN; i++) la_buf[i] = alpha[$urandom_range(0, 2)];
      run_search(wl, $urandom_range(0, 3), 1'b1, 1'b0, 0, 0, 0, $sformatf("rand%0d", it));
    end

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
